clk_period_meter: RTL and testbench

Measures the period of a slow square wave arriving on a general-purpose input, in units of the system clock, and reports whether that period is stable and matches an expected value. It is the receiving end of our ripple clock-divider outputs: a divided clock produced by one design is fed back into this block, which checks its ratio. It sits between a `ui_in` pin and the status and readout outputs (`uo_out` and `uio_out`).

---
 rtl/clk_period_meter.sv | 143 ++++++++++++++
 tb/tb_clk_period_meter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the rising-to-rising period of a slow, asynchronous square wave in
// units of clk. It reports whether the last two periods agree (lock) and
// whether a locked period equals an expected value (match). A sticky overflow
// flag reports that no edge arrived before the counter saturated.
//
// Parameters
//   CNT_W        width of the period counter and of every period value
//   SYNC_STAGES  number of input synchronizer flops (must be >= 2)
//
// Ports
//   clk            system clock, the only clock domain
//   rst            asynchronous, active-high reset
//   sig_in         asynchronous square wave to be measured
//   clr            synchronous clear of measurement state and overflow
//   expect_period  expected period in clk cycles
//   period         last measured rising-to-rising period
//   valid          one-cycle pulse on every period update
//   lock           last two measured periods were equal
//   match          lock && (period == expect_period), one cycle behind lock
//   overflow       sticky: counter saturated without seeing a rising edge
// -----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr,
    input  logic [CNT_W-1:0] expect_period,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             lock,
    output logic             match,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       period_q;
    logic                   valid_q;
    logic                   lock_q;
    logic                   match_q;
    logic                   overflow_q;

    // Input synchronizer plus one history flop for edge detection. A clear
    // deliberately leaves these alone so the input view stays continuous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Measurement FSM with all outputs registered. Priority is
    // rst > clr > rise > saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
            match_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            // A rise arriving together with clr is intentionally dropped.
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            lock_q     <= 1'b0;
            match_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // match trails lock/period by one cycle on purpose.
            match_q <= lock_q && (period_q == expect_period);
            case (state_q)
                ST_IDLE: begin
                    // The first edge only opens a period; nothing to report.
                    if (rise) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_MEASURE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        // period_q still holds the previous period here, so
                        // comparing against it yields "last two were equal".
                        period_q <= cnt_q;
                        lock_q   <= (cnt_q == period_q);
                        valid_q  <= 1'b1;
                        cnt_q    <= CNT_ONE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q    <= cnt_q + CNT_ONE;
                    end else begin
                        // Saturated: give up on this period but keep the last
                        // good value visible.
                        overflow_q <= 1'b1;
                        lock_q     <= 1'b0;
                        match_q    <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign lock     = lock_q;
    assign match    = match_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// Testbench for clk_period_meter. Stimulus is a square wave built from
// (period, high-time, repetitions) segments. The reference model works on the
// timestamps of the rising edges the bench drives: the expected period is the
// distance between consecutive edges, lock is "same as the previous period",
// and a gap larger than 2^CNT_W-1 restarts measurement from scratch. The
// constant synchronizer latency cancels out, so the bench checks that every
// report shows the same latency, within the synchronizer's range.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int MAXC        = (1 << CNT_W) - 1;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             sig_in = 1'b0;
    logic             clr    = 1'b0;
    logic [CNT_W-1:0] expect_period = '0;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             lock;
    logic             match;
    logic             overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Observed reports (filled by the monitor).
    int v_cyc[$];
    int v_per[$];
    bit v_lock[$];
    bit v_match[$];
    int ovf_q[$];
    bit mon_pv = 1'b0;
    bit mon_po = 1'b0;

    // Reference model state and expectations.
    int m_idle   = 1;
    int m_last   = 0;
    int m_period = 0;
    int exp_per[$];
    bit exp_lock[$];
    int exp_edge[$];

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sig_in        (sig_in),
        .clr           (clr),
        .expect_period (expect_period),
        .period        (period),
        .valid         (valid),
        .lock          (lock),
        .match         (match),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample outputs on the falling edge.
    always @(negedge clk) begin
        if (mon_pv) v_match.push_back(match);
        if (valid) begin
            v_cyc.push_back(cyc);
            v_per.push_back(int'(period));
            v_lock.push_back(lock);
        end
        if (overflow && !mon_po) ovf_q.push_back(cyc);
        mon_pv <= valid;
        mon_po <= overflow;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void model_edge(int t);
        if (m_idle != 0 || (t - m_last) > MAXC) begin
            m_idle = 0;
            m_last = t;
        end else begin
            exp_per.push_back(t - m_last);
            exp_lock.push_back((t - m_last) == m_period);
            exp_edge.push_back(t);
            m_period = t - m_last;
            m_last   = t;
        end
    endfunction

    task automatic drive(bit v);
        @(negedge clk);
        if (v && !sig_in) model_edge(cyc);
        sig_in = v;
    endtask

    task automatic wave(int n, int h, int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++) drive(i < h);
    endtask

    task automatic close_edge();
        drive(1'b1);
        drive(1'b0);
    endtask

    task automatic sync_clear(int ep);
        expect_period = ep[CNT_W-1:0];
        repeat (8) drive(1'b0);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        repeat (2) @(negedge clk);
        m_idle = 1; m_period = 0; m_last = 0;
        v_cyc.delete(); v_per.delete(); v_lock.delete(); v_match.delete(); ovf_q.delete();
        exp_per.delete(); exp_lock.delete(); exp_edge.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({period, valid, lock, match, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_hold: got period=%0d valid=%0b lock=%0b match=%0b overflow=%0b, want all 0", period, valid, lock, match, overflow);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({period, valid, lock, match, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_release: got period=%0d valid=%0b lock=%0b match=%0b overflow=%0b, want all 0", period, valid, lock, match, overflow);
        end
        expect_period = 8'd4;
        fork
            wave(4, 2, 12);
            begin
                repeat (24) @(negedge clk);
                total++;
                if (period !== 8'd4 || lock !== 1'b1 || match !== 1'b1) begin
                    bad++;
                    $display("FAIL reset_prestream: got period=%0d lock=%0b match=%0b, want 4 1 1", period, lock, match);
                end
                #2 rst = 1'b1;
                #1;
                total++;
                if ({period, valid, lock, match, overflow} !== '0) begin
                    bad++;
                    $display("FAIL reset_async: got period=%0d valid=%0b lock=%0b match=%0b overflow=%0b, want all 0", period, valid, lock, match, overflow);
                end
            end
        join
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_div4();
        int ep;
        int lat0;
        for (int pass = 0; pass < 2; pass++) begin
            ep = (pass == 0) ? 4 : 2;
            sync_clear(ep);
            wave(4, 2, 6); close_edge(); repeat (8) drive(1'b0);
            total++;
            if (v_per.size() != exp_per.size() || exp_per.size() != 6) begin
                bad++;
                $display("FAIL div4_count ep=%0d: got %0d valids, want %0d (model %0d)", ep, v_per.size(), 6, exp_per.size());
            end
            lat0 = (v_cyc.size() > 0 && exp_edge.size() > 0) ? v_cyc[0] - exp_edge[0] : -1;
            total++;
            if (lat0 < SYNC_STAGES + 1 || lat0 > SYNC_STAGES + 2) begin
                bad++;
                $display("FAIL div4_latency: got %0d, want %0d..%0d", lat0, SYNC_STAGES + 1, SYNC_STAGES + 2);
            end
            for (int i = 0; i < exp_per.size(); i++) begin
                total++;
                if (i >= v_per.size() || i >= v_match.size()) begin
                    bad++;
                    $display("FAIL div4 ep=%0d valid#%0d: missing, want period=%0d", ep, i, exp_per[i]);
                end else if (v_per[i] != exp_per[i] || v_lock[i] != exp_lock[i] ||
                             v_match[i] != (exp_lock[i] && exp_per[i] == ep) || v_cyc[i] - exp_edge[i] != lat0) begin
                    bad++;
                    $display("FAIL div4 ep=%0d valid#%0d: got period=%0d lock=%0b match=%0b lat=%0d, want period=%0d lock=%0b match=%0b lat=%0d",
                             ep, i, v_per[i], v_lock[i], v_match[i], v_cyc[i] - exp_edge[i],
                             exp_per[i], exp_lock[i], (exp_lock[i] && exp_per[i] == ep), lat0);
                end
            end
        end
    endtask

    task automatic test_ratio_change();
        int lat0;
        sync_clear(8);
        wave(4, 2, 5); wave(8, 4, 4); close_edge(); repeat (8) drive(1'b0);
        total++;
        if (v_per.size() != exp_per.size()) begin
            bad++;
            $display("FAIL ratio_count: got %0d valids, want %0d", v_per.size(), exp_per.size());
        end
        lat0 = (v_cyc.size() > 0 && exp_edge.size() > 0) ? v_cyc[0] - exp_edge[0] : -1;
        for (int i = 0; i < exp_per.size(); i++) begin
            total++;
            if (i >= v_per.size() || i >= v_match.size()) begin
                bad++;
                $display("FAIL ratio valid#%0d: missing, want period=%0d", i, exp_per[i]);
            end else if (v_per[i] != exp_per[i] || v_lock[i] != exp_lock[i] ||
                         v_match[i] != (exp_lock[i] && exp_per[i] == 8) || v_cyc[i] - exp_edge[i] != lat0) begin
                bad++;
                $display("FAIL ratio valid#%0d: got period=%0d lock=%0b match=%0b lat=%0d, want period=%0d lock=%0b match=%0b lat=%0d",
                         i, v_per[i], v_lock[i], v_match[i], v_cyc[i] - exp_edge[i],
                         exp_per[i], exp_lock[i], (exp_lock[i] && exp_per[i] == 8), lat0);
            end
        end
    endtask

    task automatic test_stall();
        int lat0;
        int lastv;
        sync_clear(4);
        wave(4, 2, 4); close_edge();
        repeat (300) drive(1'b0);
        lastv = (v_cyc.size() > 0) ? v_cyc[v_cyc.size() - 1] : -1000;
        total++;
        if (ovf_q.size() != 1 || ovf_q[0] - lastv != MAXC) begin
            bad++;
            $display("FAIL stall_ovf_time: got %0d overflow rises, first %0d cycles after last valid, want 1 rise at %0d",
                     ovf_q.size(), (ovf_q.size() > 0) ? ovf_q[0] - lastv : -1, MAXC);
        end
        total++;
        if (overflow !== 1'b1 || lock !== 1'b0 || match !== 1'b0 || period !== 8'd4) begin
            bad++;
            $display("FAIL stall_state: got overflow=%0b lock=%0b match=%0b period=%0d, want 1 0 0 4", overflow, lock, match, period);
        end
        wave(6, 3, 3); close_edge(); repeat (8) drive(1'b0);
        lat0 = (v_cyc.size() > 0 && exp_edge.size() > 0) ? v_cyc[0] - exp_edge[0] : -1;
        total++;
        if (v_per.size() != exp_per.size() || exp_per.size() != 7) begin
            bad++;
            $display("FAIL stall_count: got %0d valids, want 7 (model %0d)", v_per.size(), exp_per.size());
        end
        for (int i = 0; i < exp_per.size(); i++) begin
            total++;
            if (i >= v_per.size()) begin
                bad++;
                $display("FAIL stall valid#%0d: missing, want period=%0d", i, exp_per[i]);
            end else if (v_per[i] != exp_per[i] || v_lock[i] != exp_lock[i] || v_cyc[i] - exp_edge[i] != lat0) begin
                bad++;
                $display("FAIL stall valid#%0d: got period=%0d lock=%0b lat=%0d, want period=%0d lock=%0b lat=%0d",
                         i, v_per[i], v_lock[i], v_cyc[i] - exp_edge[i], exp_per[i], exp_lock[i], lat0);
            end
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL stall_sticky: got overflow=%0b, want 1", overflow);
        end
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        total++;
        if (overflow !== 1'b0 || period !== 8'd0) begin
            bad++;
            $display("FAIL stall_clr: got overflow=%0b period=%0d, want 0 0", overflow, period);
        end
    endtask

    task automatic test_simul_clear();
        int n;
        int h;
        int vcl;
        int k;
        n   = $urandom_range(4, 10);
        h   = $urandom_range(1, n - 1);
        vcl = -1;
        sync_clear(n);
        fork
            begin
                wave(n, h, 8); close_edge(); repeat (8) drive(1'b0);
            end
            begin
                for (k = 0; k < 400 && v_cyc.size() < 3; k++) @(negedge clk);
                total++;
                if (v_cyc.size() < 3) begin
                    bad++;
                    $display("FAIL simclr_wait: got %0d valids after %0d cycles, want 3", v_cyc.size(), k);
                end else begin
                    vcl = v_cyc[2] + n;
                    while (cyc < vcl - 1) @(negedge clk);
                    clr = 1'b1;
                    @(negedge clk);
                    clr = 1'b0;
                    if (valid !== 1'b0 || period !== 8'd0 || lock !== 1'b0) begin
                        bad++;
                        $display("FAIL simclr_cycle: got valid=%0b period=%0d lock=%0b at cyc %0d, want 0 0 0 at %0d", valid, period, lock, cyc, vcl);
                    end
                end
            end
        join
        total++;
        if (v_cyc.size() != 6) begin
            bad++;
            $display("FAIL simclr_count: got %0d valids, want 6 (n=%0d)", v_cyc.size(), n);
        end
        for (int i = 3; i < 5; i++) begin
            total++;
            if (i >= v_cyc.size()) begin
                bad++;
                $display("FAIL simclr_after#%0d: missing valid, want cyc=%0d", i - 3, vcl + (i - 1) * n);
            end else if (v_cyc[i] != vcl + (i - 1) * n || v_per[i] != n || v_lock[i] != (i == 4)) begin
                bad++;
                $display("FAIL simclr_after#%0d: got cyc=%0d period=%0d lock=%0b, want cyc=%0d period=%0d lock=%0b",
                         i - 3, v_cyc[i], v_per[i], v_lock[i], vcl + (i - 1) * n, n, (i == 4));
            end
        end
    endtask

    task automatic test_min_period();
        int lat0;
        sync_clear(2);
        wave(2, 1, 6);
        wave(255, $urandom_range(1, 254), 2);
        close_edge(); repeat (8) drive(1'b0);
        lat0 = (v_cyc.size() > 0 && exp_edge.size() > 0) ? v_cyc[0] - exp_edge[0] : -1;
        total++;
        if (v_per.size() != exp_per.size() || exp_per.size() != 8) begin
            bad++;
            $display("FAIL minp_count: got %0d valids, want 8 (model %0d)", v_per.size(), exp_per.size());
        end
        for (int i = 0; i < exp_per.size(); i++) begin
            total++;
            if (i >= v_per.size() || i >= v_match.size()) begin
                bad++;
                $display("FAIL minp valid#%0d: missing, want period=%0d", i, exp_per[i]);
            end else if (v_per[i] != exp_per[i] || v_lock[i] != exp_lock[i] ||
                         v_match[i] != (exp_lock[i] && exp_per[i] == 2) || v_cyc[i] - exp_edge[i] != lat0) begin
                bad++;
                $display("FAIL minp valid#%0d: got period=%0d lock=%0b match=%0b lat=%0d, want period=%0d lock=%0b match=%0b lat=%0d",
                         i, v_per[i], v_lock[i], v_match[i], v_cyc[i] - exp_edge[i],
                         exp_per[i], exp_lock[i], (exp_lock[i] && exp_per[i] == 2), lat0);
            end
        end
        total++;
        if (overflow !== 1'b0 || ovf_q.size() != 0 || period !== 8'd255) begin
            bad++;
            $display("FAIL minp_sat: got overflow=%0b rises=%0d period=%0d, want 0 0 255", overflow, ovf_q.size(), period);
        end
    endtask

    task automatic test_random();
        int ep;
        int n;
        int h;
        int lat0;
        for (int round = 0; round < 3; round++) begin
            ep = $urandom_range(2, 20);
            sync_clear(ep);
            for (int s = 0; s < 6; s++) begin
                n = (s == 0) ? ep : $urandom_range(2, 20);
                h = $urandom_range(1, n - 1);
                wave(n, h, $urandom_range(1, 4));
            end
            close_edge(); repeat (8) drive(1'b0);
            lat0 = (v_cyc.size() > 0 && exp_edge.size() > 0) ? v_cyc[0] - exp_edge[0] : -1;
            total++;
            if (v_per.size() != exp_per.size()) begin
                bad++;
                $display("FAIL rand_count round=%0d: got %0d valids, want %0d", round, v_per.size(), exp_per.size());
            end
            for (int i = 0; i < exp_per.size(); i++) begin
                total++;
                if (i >= v_per.size() || i >= v_match.size()) begin
                    bad++;
                    $display("FAIL rand round=%0d valid#%0d: missing, want period=%0d", round, i, exp_per[i]);
                end else if (v_per[i] != exp_per[i] || v_lock[i] != exp_lock[i] ||
                             v_match[i] != (exp_lock[i] && exp_per[i] == ep) || v_cyc[i] - exp_edge[i] != lat0) begin
                    bad++;
                    $display("FAIL rand round=%0d valid#%0d: got period=%0d lock=%0b match=%0b lat=%0d, want period=%0d lock=%0b match=%0b lat=%0d",
                             round, i, v_per[i], v_lock[i], v_match[i], v_cyc[i] - exp_edge[i],
                             exp_per[i], exp_lock[i], (exp_lock[i] && exp_per[i] == ep), lat0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_ratio_change();
        test_stall();
        test_simul_clear();
        test_min_period();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
